// File: rtl/uart_tx_parity_unit_if.sv
// Bus between the Tx data register / Tx FSM and the parity unit.
// The err_inj request line exists only when UART_TX_PARITY_ERR_INJ_EN is defined.
interface uart_tx_parity_unit_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned LEN_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic [1:0]            PAR_TYP;
    logic [LEN_W-1:0]      DATA_LEN;
`ifdef UART_TX_PARITY_ERR_INJ_EN
    logic                  err_inj;
`endif
    logic                  busy;
    logic                  par_bit;
    logic                  par_done;

    // Requester side (Tx FSM / data register)
    modport master (
`ifdef UART_TX_PARITY_ERR_INJ_EN
        output err_inj,
`endif
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, DATA_LEN,
        input  busy, par_bit, par_done
    );

    // Parity unit side
    modport slave (
`ifdef UART_TX_PARITY_ERR_INJ_EN
        input  err_inj,
`endif
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, DATA_LEN,
        output busy, par_bit, par_done
    );
endinterface

// File: rtl/uart_tx_parity_unit.sv
// Multi-cycle UART Tx parity generator: folds CHUNK data bits per cycle into a
// one-bit accumulator, then produces even/odd/mark/space parity for a frame of
// run-time length. Optional macro UART_TX_PARITY_ERR_INJ_EN adds err_inj, which
// inverts the final parity bit of a frame when set at the accept edge.
module uart_tx_parity_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHUNK      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_parity_unit_if.slave  bus
);
    localparam int unsigned LEN_W = $clog2(DATA_WIDTH + 1);
    // Counter must reach DATA_WIDTH+CHUNK without wrapping
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + CHUNK + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]            state_q,   state_d;
    logic                  busy_q,    busy_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_done_q, par_done_d;
    logic                  acc_q,     acc_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [LEN_W-1:0]      len_q,     len_d;
    logic [1:0]            typ_q,     typ_d;
`ifdef UART_TX_PARITY_ERR_INJ_EN
    logic                  inj_q,     inj_d;
`endif

    logic [LEN_W-1:0]      eff_len;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  acc_nxt;
    logic                  last_chunk;
    logic                  fin_par;

    // Effective frame length: 0 or out-of-range lengths select the full width
    always_comb begin
        eff_len = bus.DATA_LEN;
        if (bus.DATA_LEN == '0 || bus.DATA_LEN > LEN_W'(DATA_WIDTH)) begin
            eff_len = LEN_W'(DATA_WIDTH);
        end
    end

    // Load value with bits beyond the frame length forced to zero
    always_comb begin
        load_data = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (i < int'(eff_len)) begin
                load_data[i] = bus.P_DATA[i];
            end
        end
    end

    // Accumulator after folding the current chunk, and last-chunk detection
    always_comb begin
        acc_nxt    = acc_q ^ (^shift_q[CHUNK-1:0]);
        last_chunk = (cnt_q + CNT_W'(CHUNK)) >= CNT_W'(len_q);
    end

    // Final parity for the captured mode (optionally inverted for error injection)
    always_comb begin
        case (typ_q)
            2'b00:   fin_par = acc_nxt;
            2'b01:   fin_par = ~acc_nxt;
            2'b10:   fin_par = 1'b1;
            default: fin_par = 1'b0;
        endcase
`ifdef UART_TX_PARITY_ERR_INJ_EN
        fin_par = fin_par ^ inj_q;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        par_bit_d  = par_bit_q;
        par_done_d = 1'b0;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        typ_d      = typ_q;
`ifdef UART_TX_PARITY_ERR_INJ_EN
        inj_d      = inj_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid && bus.PAR_EN) begin
                    len_d   = eff_len;
                    typ_d   = bus.PAR_TYP;
                    shift_d = load_data;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
`ifdef UART_TX_PARITY_ERR_INJ_EN
                    inj_d   = bus.err_inj;
`endif
                end
            end
            S_CALC: begin
                acc_d   = acc_nxt;
                shift_d = shift_q >> CHUNK;
                cnt_d   = cnt_q + CNT_W'(CHUNK);
                if (last_chunk) begin
                    par_bit_d  = fin_par;
                    par_done_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            par_done_q <= 1'b0;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            typ_q      <= '0;
`ifdef UART_TX_PARITY_ERR_INJ_EN
            inj_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            par_bit_q  <= par_bit_d;
            par_done_q <= par_done_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            typ_q      <= typ_d;
`ifdef UART_TX_PARITY_ERR_INJ_EN
            inj_q      <= inj_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.par_bit  = par_bit_q;
    assign bus.par_done = par_done_q;
endmodule

// File: doc/uart_tx_parity_unit.md
Name: uart_tx_parity_unit

Overview:
Parametrised, multi-cycle parity generator for the UART transmitter, successor to the fixed 8-bit single-cycle parity calculator.
- Supports run-time frame length (1..DATA_WIDTH bits).
- Four parity modes: even, odd, mark, space.
- Folds CHUNK bits per cycle through an accumulator, trading latency for area/power.
- Sits between the Tx data register and the Tx FSM/mux. The FSM waits on par_done before emitting the parity slot.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (>=1).
CHUNK, 2, bits folded into the accumulator per CALC cycle (1..DATA_WIDTH).
LEN_W, $clog2(DATA_WIDTH+1), width of DATA_LEN (localparam, derived).

Ports:
CLK  in  1  single clock; all logic on its rising edge.
RST  in  1  synchronous, active-high reset.
P_DATA  in  DATA_WIDTH  parallel frame data, LSB first.
Data_Valid  in  1  request to compute parity on P_DATA.
PAR_EN  in  1  parity enable; requests with PAR_EN=0 are ignored.
PAR_TYP  in  2  00 even, 01 odd, 10 mark (1), 11 space (0).
DATA_LEN  in  LEN_W  number of valid data bits; 0 or >DATA_WIDTH means DATA_WIDTH.
busy  out  1  high while a calculation is in progress.
par_bit  out  1  latest computed parity bit; holds between calculations.
par_done  out  1  one-cycle pulse when par_bit has just been updated.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST.
- Reset: state=IDLE, busy=0, par_bit=0, par_done=0, accumulator=0, counter=0. Reset asserted mid-CALC aborts the operation; no par_done is produced.
- States: IDLE, CALC.
- IDLE, Data_Valid=1 and PAR_EN=1 (accept):
  - Capture the effective length L (clamped/defaulted) and PAR_TYP.
  - Load the shift register with P_DATA, zeroing bits at index >= L.
  - Clear the accumulator, set counter=0, go to CALC. busy=1 from the next cycle.
- IDLE, Data_Valid=1 and PAR_EN=0: ignored; par_bit holds; no par_done.
- CALC, each cycle:
  - acc ^= XOR of the shift register's low CHUNK bits.
  - Shift right by CHUNK (zero fill). counter += CHUNK.
  - On the cycle where counter+CHUNK >= L (last chunk), at the same edge:
    - par_bit <= even: acc_final; odd: ~acc_final; mark: 1; space: 0.
    - par_done <= 1; busy <= 0; state <= IDLE.
- Latency: ceil(L/CHUNK) CALC cycles after the accept edge. Mark/space use the same latency, so timing is mode-independent.
- par_done is high exactly one cycle, the first IDLE cycle after completion. A new request in that cycle is accepted (back-to-back operation).
- Data_Valid while busy: ignored, not queued.
- PAR_EN, PAR_TYP, DATA_LEN or P_DATA changing during CALC has no effect on the in-flight result.
- counter must be wide enough to hold DATA_WIDTH+CHUNK without wrap.

Optional Feature:
- Macro: UART_TX_PARITY_ERR_INJ_EN.
- Defined:
  - Extra input port err_inj (1 bit) is present.
  - err_inj is sampled at the accept edge. If it was 1, the final par_bit for that frame is inverted (all four modes). Used for receiver parity-error testing.
- Undefined:
  - err_inj port is absent.
  - par_bit is never inverted.

Test Plan:
- Reset: assert RST for 2 cycles during an active CALC -> busy=0, par_bit=0, par_done=0; no par_done pulse afterwards.
- DATA_WIDTH=8, CHUNK=2, P_DATA=0xA5, DATA_LEN=8, PAR_TYP=00, then 01 -> par_bit 0, then 1. par_done fires 4 cycles after accept; busy high for exactly 4 cycles.
- P_DATA=0xFF, DATA_LEN=5, PAR_TYP=00 -> par_bit=1 (upper bits masked), latency 3 cycles. Repeat with DATA_LEN=0 -> par_bit=0, latency 4.
- PAR_TYP=10 and 11 with P_DATA=0x07 -> par_bit 1 and 0, each with latency 4. Data_Valid with PAR_EN=0 -> no busy, no par_done, par_bit unchanged.
- Back-to-back: new request (0x01, even) in the par_done cycle of a previous 0x03 request -> second par_done 4 cycles later with par_bit=1. Data_Valid pulses while busy are ignored.
- With UART_TX_PARITY_ERR_INJ_EN: err_inj=1 at accept, P_DATA=0xA5, even -> par_bit=1. Next frame with err_inj=0 -> par_bit=0.
